// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonar_pkg
// Brief    : Shared types and default constants for the sonar sweep scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sonar_pkg;

    // Scheduler phase encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BURST  = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_REPORT = 3'd4
    } sched_state_t;

    // Default sweep geometry (degrees)
    localparam int DEF_ANGLE_WIDTH = 8;
    localparam int DEF_ANGLE_MIN   = -30;
    localparam int DEF_ANGLE_MAX   = 30;
    localparam int DEF_ANGLE_STEP  = 10;

    // Default ping timing (clock cycles)
    localparam int DEF_PERIOD_CYCLES = 16777216;
    localparam int DEF_BURST_CYCLES  = 524288;
    localparam int DEF_BLANK_CYCLES  = 65536;
    localparam int DEF_RANGE_WIDTH   = 16;

endpackage
`default_nettype wire

// File: rtl/angle_stepper.sv
`default_nettype none
// ============================================================================
// Module   : angle_stepper
// Brief    : Holds the steering angle and advances it on a step strobe.
//            Flags when the current angle is a sweep endpoint.
//            Build option SWEEP_BIDIR_EN selects a ping-pong sweep with a
//            direction register; otherwise the angle wraps MAX -> MIN.
// Revision : 1.0 - initial release
// ============================================================================
import sonar_pkg::*;

module angle_stepper #(
    parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN   = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX   = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP  = DEF_ANGLE_STEP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step,
    output logic signed [ANGLE_WIDTH-1:0] angle,
    output logic                          at_end
);

    localparam logic signed [ANGLE_WIDTH-1:0] C_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] C_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] C_STEP = ANGLE_WIDTH'(ANGLE_STEP);

    logic signed [ANGLE_WIDTH-1:0] r_angle;

`ifdef SWEEP_BIDIR_EN
    logic r_dir_down;

    // Ping-pong: each endpoint is visited once, then the direction flips
    always_ff @(posedge clk) begin
        if (rst) begin
            r_angle    <= C_MIN;
            r_dir_down <= 1'b0;
        end else if (step) begin
            if (!r_dir_down) begin
                if (r_angle == C_MAX) begin
                    r_dir_down <= 1'b1;
                    r_angle    <= C_MAX - C_STEP;
                end else begin
                    r_angle <= r_angle + C_STEP;
                end
            end else begin
                if (r_angle == C_MIN) begin
                    r_dir_down <= 1'b0;
                    r_angle    <= C_MIN + C_STEP;
                end else begin
                    r_angle <= r_angle - C_STEP;
                end
            end
        end
    end

    // Both extremes count as the end of a sweep leg
    always_comb begin
        at_end = (r_angle == C_MIN) || (r_angle == C_MAX);
    end
`else
    // Unidirectional sweep wrapping from the last angle back to the first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_angle <= C_MIN;
        end else if (step) begin
            r_angle <= (r_angle == C_MAX) ? C_MIN : (r_angle + C_STEP);
        end
    end

    // Only the last angle of the sweep ends it
    always_comb begin
        at_end = (r_angle == C_MAX);
    end
`endif

    assign angle = r_angle;

endmodule
`default_nettype wire

// File: rtl/sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sweep_scheduler
// Brief    : Ping sequencer: burst -> blanking -> listen -> report, one
//            steering angle per period. Captures the first echo of each
//            listen window and emits a per-angle result record.
//            Build option SWEEP_BIDIR_EN selects a ping-pong angle sweep.
// Revision : 1.0 - initial release
// ============================================================================
import sonar_pkg::*;

module sweep_scheduler #(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          echo_valid_in,
    input  logic [RANGE_WIDTH-1:0]        echo_range_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_out,
    output logic                          burst_start_out,
    output logic                          listen_out,
    output logic                          busy_out,
    output logic                          result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [RANGE_WIDTH-1:0]        result_range_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);

    localparam logic [CNT_W-1:0] C_BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST  = CNT_W'(BURST_CYCLES + BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (BURST_CYCLES + BLANK_CYCLES >= PERIOD_CYCLES) begin : g_chk_timing
        $error("sweep_scheduler: BURST_CYCLES+BLANK_CYCLES must be < PERIOD_CYCLES");
    end
    if (BURST_CYCLES < 1) begin : g_chk_burst
        $error("sweep_scheduler: BURST_CYCLES must be at least 1");
    end
    if ((ANGLE_STEP <= 0) || (ANGLE_MAX <= ANGLE_MIN) ||
        (((ANGLE_MAX - ANGLE_MIN) % ANGLE_STEP) != 0)) begin : g_chk_angle
        $error("sweep_scheduler: angle range must be a positive multiple of ANGLE_STEP");
    end

    sched_state_t                  r_state;
    sched_state_t                  w_state_next;
    logic [CNT_W-1:0]              r_phase_cnt;
    logic                          r_cap_hit;
    logic [RANGE_WIDTH-1:0]        r_cap_range;
    logic                          w_burst_entry;
    logic                          w_at_end;
    logic signed [ANGLE_WIDTH-1:0] w_angle;

    // Angle advances on the REPORT edge, keeping it stable across the ping
    angle_stepper #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_MIN   (ANGLE_MIN),
        .ANGLE_MAX   (ANGLE_MAX),
        .ANGLE_STEP  (ANGLE_STEP)
    ) u_angle_stepper (
        .clk    (clk_in),
        .rst    (rst_in),
        .step   (r_state == S_REPORT),
        .angle  (w_angle),
        .at_end (w_at_end)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and phase outputs
    always_comb begin
        w_state_next     = r_state;
        burst_out        = 1'b0;
        burst_start_out  = 1'b0;
        listen_out       = 1'b0;
        busy_out         = 1'b1;
        result_valid_out = 1'b0;
        result_angle_out = '0;
        result_range_out = '0;
        result_hit_out   = 1'b0;
        sweep_done_out   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (enable_in) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                burst_out       = 1'b1;
                burst_start_out = (r_phase_cnt == '0);
                if (r_phase_cnt == C_BURST_LAST) begin
                    w_state_next = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_phase_cnt == C_BLANK_LAST) begin
                    w_state_next = S_LISTEN;
                end
            end
            S_LISTEN: begin
                listen_out = 1'b1;
                if (r_phase_cnt == C_PERIOD_LAST) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                result_valid_out = 1'b1;
                result_angle_out = w_angle;
                result_range_out = r_cap_range;
                result_hit_out   = r_cap_hit;
                sweep_done_out   = w_at_end;
                w_state_next     = enable_in ? S_BURST : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A new period begins whenever the FSM enters BURST
    assign w_burst_entry = (w_state_next == S_BURST) && (r_state != S_BURST);

    // Phase counter: 0 in the first BURST cycle, counts through LISTEN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_phase_cnt <= '0;
        end else if ((r_state == S_IDLE) || (r_state == S_REPORT)) begin
            r_phase_cnt <= '0;
        end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    // First-echo capture; only LISTEN echoes count, cleared for each new ping
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cap_hit   <= 1'b0;
            r_cap_range <= '0;
        end else if (w_burst_entry) begin
            r_cap_hit   <= 1'b0;
            r_cap_range <= '0;
        end else if ((r_state == S_LISTEN) && echo_valid_in && !r_cap_hit) begin
            r_cap_hit   <= 1'b1;
            r_cap_range <= echo_range_in;
        end
    end

    assign beam_angle_out = w_angle;

endmodule
`default_nettype wire

// File: tb/tb_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sweep_scheduler
// Brief    : Scoreboard bench for sweep_scheduler with a short ping period.
//            A driver plans echoes per period and queues the expected result;
//            a monitor compares each result strobe against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sweep_scheduler;

    localparam int P     = 100;
    localparam int B     = 10;
    localparam int K     = 5;
    localparam int AW    = 8;
    localparam int RW    = 16;
    localparam int AMIN  = -30;
    localparam int AMAX  = 30;
    localparam int ASTEP = 10;
    localparam int NANG  = (AMAX - AMIN) / ASTEP + 1;
    localparam int LS    = B + K;   // first listen offset within a period

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 enable_in;
    logic                 echo_valid_in;
    logic [RW-1:0]        echo_range_in;
    logic signed [AW-1:0] beam_angle_out;
    logic                 burst_out;
    logic                 burst_start_out;
    logic                 listen_out;
    logic                 busy_out;
    logic                 result_valid_out;
    logic signed [AW-1:0] result_angle_out;
    logic [RW-1:0]        result_range_out;
    logic                 result_hit_out;
    logic                 sweep_done_out;

    sweep_scheduler #(
        .PERIOD_CYCLES (P),
        .BURST_CYCLES  (B),
        .BLANK_CYCLES  (K),
        .ANGLE_WIDTH   (AW),
        .ANGLE_MIN     (AMIN),
        .ANGLE_MAX     (AMAX),
        .ANGLE_STEP    (ASTEP),
        .RANGE_WIDTH   (RW)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .echo_valid_in    (echo_valid_in),
        .echo_range_in    (echo_range_in),
        .beam_angle_out   (beam_angle_out),
        .burst_out        (burst_out),
        .burst_start_out  (burst_start_out),
        .listen_out       (listen_out),
        .busy_out         (busy_out),
        .result_valid_out (result_valid_out),
        .result_angle_out (result_angle_out),
        .result_range_out (result_range_out),
        .result_hit_out   (result_hit_out),
        .sweep_done_out   (sweep_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int angle;
        int rng;
        bit hit;
        bit done;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_start;
    int            gap_expect;
    int            seq_pos;
    bit            plan_v [P];
    logic [RW-1:0] plan_r [P];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sweep sequence as a position in a repeating list of angle indices
`ifdef SWEEP_BIDIR_EN
    localparam int SEQ_LEN = 2 * NANG - 2;
    function automatic int model_angle(input int pos);
        int idx;
        idx = (pos < NANG) ? pos : (SEQ_LEN - pos);
        return AMIN + idx * ASTEP;
    endfunction
    function automatic bit model_done(input int ang);
        return (ang == AMIN) || (ang == AMAX);
    endfunction
`else
    localparam int SEQ_LEN = NANG;
    function automatic int model_angle(input int pos);
        return AMIN + pos * ASTEP;
    endfunction
    function automatic bit model_done(input int ang);
        return ang == AMAX;
    endfunction
`endif

    task automatic clear_plan();
        for (int k = 0; k < P; k++) begin
            plan_v[k] = 1'b0;
            plan_r[k] = '0;
        end
    endtask

    task automatic random_plan();
        int mode;
        mode = $urandom_range(0, 3);
        for (int k = 0; k < P; k++) begin
            plan_v[k] = (mode != 0) && ($urandom_range(0, 24) == 0);
            plan_r[k] = RW'($urandom);
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_burst_start();
        int n;
        n = 0;
        while (!burst_start_out && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        if (!burst_start_out) begin
            checks++;
            errors++;
            $display("FAIL burst_start_timeout actual=none expected=pulse (cycle %0d)", cyc);
            finish_now();
        end
    endtask

    // One full ping: queue the expected record, then drive the planned echoes
    task automatic run_period(input bit drop_enable);
        exp_t e;
        e.hit = 1'b0;
        e.rng = 0;
        for (int k = LS; k < P; k++) begin
            if (plan_v[k] && !e.hit) begin
                e.hit = 1'b1;
                e.rng = int'(plan_r[k]);
            end
        end
        e.angle = model_angle(seq_pos);
        e.done  = model_done(e.angle);
        sb_q.push_back(e);

        wait_burst_start();
        chk("burst_gap", cyc - last_start, gap_expect);
        last_start = cyc;
        gap_expect = P + 1;

        for (int k = 0; k < P; k++) begin
            echo_valid_in = plan_v[k];
            echo_range_in = plan_r[k];
            chk("burst_start", int'(burst_start_out), int'(k == 0));
            chk("burst_gate", int'(burst_out), int'(k < B));
            chk("listen_gate", int'(listen_out), int'(k >= LS));
            if (k == 0 || k == P - 1) begin
                chk("beam_angle", int'(beam_angle_out), e.angle);
                chk("busy", int'(busy_out), 1);
            end
            if (drop_enable && k == LS + 40) begin
                enable_in = 1'b0;
            end
            @(negedge clk_in);
        end
        echo_valid_in = 1'b0;
        seq_pos = (seq_pos + 1) % SEQ_LEN;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_beam_angle"}, int'(beam_angle_out), AMIN);
        chk({tag, "_burst"}, int'(burst_out), 0);
        chk({tag, "_burst_start"}, int'(burst_start_out), 0);
        chk({tag, "_listen"}, int'(listen_out), 0);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_result_valid"}, int'(result_valid_out), 0);
        chk({tag, "_result_angle"}, int'(result_angle_out), 0);
        chk({tag, "_result_range"}, int'(result_range_out), 0);
        chk({tag, "_result_hit"}, int'(result_hit_out), 0);
        chk({tag, "_sweep_done"}, int'(sweep_done_out), 0);
    endtask

    // Monitor: every result strobe must match the oldest queued expectation
    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (result_valid_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected actual=angle %0d expected=no result", result_angle_out);
            end else begin
                e = sb_q.pop_front();
                chk("result_angle", int'(result_angle_out), e.angle);
                chk("result_range", int'(result_range_out), e.rng);
                chk("result_hit", int'(result_hit_out), int'(e.hit));
                chk("sweep_done", int'(sweep_done_out), int'(e.done));
            end
        end else if (sweep_done_out) begin
            checks++;
            errors++;
            $display("FAIL sweep_done_orphan actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_in        = 1'b1;
        enable_in     = 1'b0;
        echo_valid_in = 1'b0;
        echo_range_in = '0;
        seq_pos       = 0;
        clear_plan();
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");

        rst_in     = 1'b0;
        enable_in  = 1'b1;
        last_start = cyc;
        gap_expect = 1;

        // First echo wins; later echo in the same window is ignored
        clear_plan();
        plan_v[LS + 20] = 1'b1; plan_r[LS + 20] = 16'h0123;
        plan_v[LS + 30] = 1'b1; plan_r[LS + 30] = 16'h0456;
        run_period(1'b0);

        // Blanking echo ignored, echo in the final listen cycle captured
        clear_plan();
        plan_v[B + 2] = 1'b1; plan_r[B + 2] = 16'd7;
        plan_v[P - 1] = 1'b1; plan_r[P - 1] = 16'd9;
        run_period(1'b0);

        // Only burst and blanking echoes: no hit
        clear_plan();
        plan_v[3]     = 1'b1; plan_r[3]     = 16'd5;
        plan_v[B + 2] = 1'b1; plan_r[B + 2] = 16'd7;
        run_period(1'b0);

        // Remaining angles of the sweep and the wrap
        for (int i = 0; i < 6; i++) begin
            random_plan();
            run_period(1'b0);
        end

        // Enable dropped mid-listen: period completes, then IDLE
        random_plan();
        run_period(1'b1);
        @(negedge clk_in);
        chk("drop_busy", int'(busy_out), 0);
        chk("drop_angle", int'(beam_angle_out), model_angle(seq_pos));
        repeat (5) @(negedge clk_in);
        chk("idle_hold_busy", int'(busy_out), 0);
        chk("idle_hold_burst", int'(burst_out), 0);

        enable_in  = 1'b1;
        last_start = cyc;
        gap_expect = 1;
        for (int i = 0; i < 2; i++) begin
            random_plan();
            run_period(1'b0);
        end

        // Reset in the middle of a burst
        wait_burst_start();
        repeat (5) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("midburst_reset");
        seq_pos    = 0;
        rst_in     = 1'b0;
        last_start = cyc;
        gap_expect = 1;
        for (int i = 0; i < 2; i++) begin
            random_plan();
            run_period(1'b0);
        end

        repeat (3) @(negedge clk_in);
        chk("scoreboard_empty", sb_q.size(), 0);
        finish_now();
    end

endmodule
`default_nettype wire
